// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the shared single-port data memory.
// Round-robin with a bounded lock for requester 1; all state moves on the falling clock edge.
`timescale 1ns/1ps

module dmem_arbiter_port #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          gnt_set,
   input  logic          rvalid_set,
   input  logic          rdata_load,
   input  logic [DW-1:0] mem_rdata,
   output logic          gnt,
   output logic          rvalid,
   output logic [DW-1:0] rdata
);
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt    <= 1'b0;
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         gnt    <= gnt_set;
         rvalid <= rvalid_set;
         if (rdata_load) rdata <= mem_rdata;
      end
   end
endmodule

module dmem_arbiter #(
   parameter int AW       = 5,
   parameter int DW       = 32,
   parameter int MEM_LAT  = 1,
   parameter int LOCK_MAX = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          r0_req,
   input  logic          r0_we,
   input  logic [AW-1:0] r0_addr,
   input  logic [DW-1:0] r0_wdata,
   output logic          r0_gnt,
   output logic          r0_rvalid,
   output logic [DW-1:0] r0_rdata,
   input  logic          r1_req,
   input  logic          r1_we,
   input  logic [AW-1:0] r1_addr,
   input  logic [DW-1:0] r1_wdata,
   output logic          r1_gnt,
   output logic          r1_rvalid,
   output logic [DW-1:0] r1_rdata,
   input  logic          r1_lock,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          owner
);
   localparam int NREQ = 2;
   localparam int CW   = 3;
   localparam int LCW  = $clog2(LOCK_MAX + 1);

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } acc_t;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t                     state_q, state_d;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic [LCW-1:0]             lock_cnt_q, lock_cnt_d;
   logic                       owner_d, last_q, last_d, op_we_q, op_we_d;
   logic                       mem_en_d, mem_we_d;
   logic [AW-1:0]              mem_addr_d;
   logic [DW-1:0]              mem_wdata_d;
   logic [NREQ-1:0]            req, gnt_d, rvalid_d, load_d;
   logic [NREQ-1:0]            gnt_q, rvalid_q;
   logic [NREQ-1:0][DW-1:0]    rdata_q;
   acc_t [NREQ-1:0]            acc;
   acc_t                       sel_acc;
   logic                       lock_ok, sel;

   assign req    = {r1_req, r0_req};
   assign acc[0] = '{we: r0_we, addr: r0_addr, wdata: r0_wdata};
   assign acc[1] = '{we: r1_we, addr: r1_addr, wdata: r1_wdata};

   // Lock only extends an ownership requester 1 already holds, and only LOCK_MAX times.
   assign lock_ok = owner & r1_lock & r1_req & (lock_cnt_q < LCW'(LOCK_MAX));

   always_comb begin
      sel = ~last_q;
      if (req == 2'b01)      sel = 1'b0;
      else if (req == 2'b10) sel = 1'b1;
      else if (lock_ok)      sel = 1'b1;
   end

   assign sel_acc = acc[sel];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      owner_d     = owner;
      last_d      = last_q;
      lock_cnt_d  = lock_cnt_q;
      op_we_d     = op_we_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      gnt_d       = '0;
      rvalid_d    = '0;
      load_d      = '0;
      if (!r1_lock) lock_cnt_d = '0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               gnt_d[sel]  = 1'b1;
               mem_en_d    = 1'b1;
               mem_we_d    = sel_acc.we;
               mem_addr_d  = sel_acc.addr;
               mem_wdata_d = sel_acc.wdata;
               op_we_d     = sel_acc.we;
               owner_d     = sel;
               last_d      = sel;
               cnt_d       = CW'(MEM_LAT);
               state_d     = WAIT;
               if (!sel)                      lock_cnt_d = '0;
               else if (lock_ok && req[0])    lock_cnt_d = lock_cnt_q + LCW'(1);
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               rvalid_d[owner] = 1'b1;
               load_d[owner]   = ~op_we_q;
               state_d         = IDLE;
            end
         end
      endcase
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         lock_cnt_q <= '0;
         owner      <= 1'b0;
         last_q     <= 1'b1;
         op_we_q    <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lock_cnt_q <= lock_cnt_d;
         owner      <= owner_d;
         last_q     <= last_d;
         op_we_q    <= op_we_d;
         mem_en     <= mem_en_d;
         mem_we     <= mem_we_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
      end
   end

   for (genvar g = 0; g < NREQ; g++) begin : g_port
      dmem_arbiter_port #(.DW(DW)) u_port (
         .clk        (clk),
         .rst_n      (rst_n),
         .gnt_set    (gnt_d[g]),
         .rvalid_set (rvalid_d[g]),
         .rdata_load (load_d[g]),
         .mem_rdata  (mem_rdata),
         .gnt        (gnt_q[g]),
         .rvalid     (rvalid_q[g]),
         .rdata      (rdata_q[g])
      );
   end

   assign r0_gnt    = gnt_q[0];
   assign r1_gnt    = gnt_q[1];
   assign r0_rvalid = rvalid_q[0];
   assign r1_rvalid = rvalid_q[1];
   assign r0_rdata  = rdata_q[0];
   assign r1_rdata  = rdata_q[1];
   assign busy      = (state_q == WAIT);
endmodule
